// File: rtl/sdrc_req_splitter.sv
// SDRAM request splitter.
// Takes one application burst and hands it to the bank controller as one or
// two sub-requests. A burst that would run past the end of its column page
// is cut at the page boundary; the remainder follows as a second request.
// The application sees a single app_req_ack once every part has been accepted.
module sdrc_req_splitter (
    input  logic        sdram_clk,
    input  logic        sdram_resetn,
    input  logic        app_req,
    input  logic [25:0] app_req_addr,
    input  logic [7:0]  app_req_len,
    input  logic        app_req_wr,
    input  logic        app_req_wrap,
    input  logic [1:0]  cfg_colbits,
    output logic        app_req_ack,
    output logic        r2b_req,
    output logic [1:0]  r2b_ba,
    output logic [12:0] r2b_raddr,
    output logic [12:0] r2b_caddr,
    output logic [7:0]  r2b_len,
    output logic        r2b_write,
    input  logic        b2r_arb_ok,
    output logic        page_ovflw
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE1 = 2'd1,
        ISSUE2 = 2'd2
    } state_e;

    // Split a linear word address into {bank, row, column} for a column
    // width of 8 + colbits bits.
    function automatic logic [27:0] map_addr(input logic [25:0] addr,
                                             input logic [1:0]  colbits);
        logic [3:0]  col_w;
        logic [25:0] col_mask;
        logic [14:0] upper;
        col_w    = 4'd8 + {2'b00, colbits};
        col_mask = (26'd1 << col_w) - 26'd1;
        upper    = 15'(addr >> col_w);
        map_addr = {upper[1:0], upper[14:2], 13'(addr & col_mask)};
    endfunction

    state_e      state_q, state_d;
    logic        r2b_req_q, r2b_req_d;
    logic [1:0]  r2b_ba_q, r2b_ba_d;
    logic [12:0] r2b_raddr_q, r2b_raddr_d;
    logic [12:0] r2b_caddr_q, r2b_caddr_d;
    logic [7:0]  r2b_len_q, r2b_len_d;
    logic        r2b_write_q, r2b_write_d;
    logic        app_req_ack_q, app_req_ack_d;
    logic        page_ovflw_q, page_ovflw_d;
    // Second half of a split request, prepared when the request is captured.
    logic        split_q, split_d;
    logic [25:0] addr2_q, addr2_d;
    logic [7:0]  len2_q, len2_d;
    logic [1:0]  colbits_q, colbits_d;

    // Split arithmetic on the incoming request.
    logic [7:0]  len_eff;
    logic [11:0] page_size;
    logic [11:0] in_caddr;
    logic        in_split;
    logic [7:0]  len1;

    // Next-state and next-output logic for the issue FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        state_d       = state_q;
        r2b_req_d     = r2b_req_q;
        r2b_ba_d      = r2b_ba_q;
        r2b_raddr_d   = r2b_raddr_q;
        r2b_caddr_d   = r2b_caddr_q;
        r2b_len_d     = r2b_len_q;
        r2b_write_d   = r2b_write_q;
        app_req_ack_d = 1'b0;
        page_ovflw_d  = page_ovflw_q;
        split_d       = split_q;
        addr2_d       = addr2_q;
        len2_d        = len2_q;
        colbits_d     = colbits_q;

        len_eff   = (app_req_len == 8'd0) ? 8'd1 : app_req_len;
        page_size = 12'd1 << (4'd8 + {2'b00, cfg_colbits});
        in_caddr  = {1'b0, app_req_addr[10:0]} & (page_size - 12'd1);
        in_split  = !app_req_wrap && ((in_caddr + {4'd0, len_eff}) > page_size);
        // Only meaningful when in_split: then it is below len_eff and fits.
        len1      = 8'(page_size - in_caddr);

        unique case (state_q)
            IDLE: begin
                // The ack cycle is skipped so the application can drop app_req.
                if (app_req && !app_req_ack_q) begin
                    state_d     = ISSUE1;
                    r2b_req_d   = 1'b1;
                    {r2b_ba_d, r2b_raddr_d, r2b_caddr_d} = map_addr(app_req_addr, cfg_colbits);
                    r2b_len_d   = in_split ? len1 : len_eff;
                    r2b_write_d = app_req_wr;
                    split_d     = in_split;
                    addr2_d     = app_req_addr + {18'd0, len1};
                    len2_d      = len_eff - len1;
                    colbits_d   = cfg_colbits;
                end
            end
            ISSUE1: begin
                if (b2r_arb_ok) begin
                    if (split_q) begin
                        state_d      = ISSUE2;
                        page_ovflw_d = 1'b1;
                        {r2b_ba_d, r2b_raddr_d, r2b_caddr_d} = map_addr(addr2_q, colbits_q);
                        r2b_len_d    = len2_q;
                    end else begin
                        state_d       = IDLE;
                        r2b_req_d     = 1'b0;
                        app_req_ack_d = 1'b1;
                    end
                end
            end
            ISSUE2: begin
                if (b2r_arb_ok) begin
                    state_d       = IDLE;
                    r2b_req_d     = 1'b0;
                    app_req_ack_d = 1'b1;
                    page_ovflw_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any request in flight.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state_q       <= IDLE;
            r2b_req_q     <= 1'b0;
            r2b_ba_q      <= 2'd0;
            r2b_raddr_q   <= 13'd0;
            r2b_caddr_q   <= 13'd0;
            r2b_len_q     <= 8'd0;
            r2b_write_q   <= 1'b0;
            app_req_ack_q <= 1'b0;
            page_ovflw_q  <= 1'b0;
            split_q       <= 1'b0;
            addr2_q       <= 26'd0;
            len2_q        <= 8'd0;
            colbits_q     <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q       <= state_d;
            r2b_req_q     <= r2b_req_d;
            r2b_ba_q      <= r2b_ba_d;
            r2b_raddr_q   <= r2b_raddr_d;
            r2b_caddr_q   <= r2b_caddr_d;
            r2b_len_q     <= r2b_len_d;
            r2b_write_q   <= r2b_write_d;
            app_req_ack_q <= app_req_ack_d;
            page_ovflw_q  <= page_ovflw_d;
            split_q       <= split_d;
            addr2_q       <= addr2_d;
            len2_q        <= len2_d;
            colbits_q     <= colbits_d;
        end
    end

    assign app_req_ack = app_req_ack_q;
    assign r2b_req     = r2b_req_q;
    assign r2b_ba      = r2b_ba_q;
    assign r2b_raddr   = r2b_raddr_q;
    assign r2b_caddr   = r2b_caddr_q;
    assign r2b_len     = r2b_len_q;
    assign r2b_write   = r2b_write_q;
    assign page_ovflw  = page_ovflw_q;

endmodule

// File: tb/tb_sdrc_req_splitter.sv
// Testbench for sdrc_req_splitter: directed and random requests checked
// against a page-arithmetic reference model of the expected sub-requests.
module tb_sdrc_req_splitter;

    logic        sdram_clk;
    logic        sdram_resetn;
    logic        app_req;
    logic [25:0] app_req_addr;
    logic [7:0]  app_req_len;
    logic        app_req_wr;
    logic        app_req_wrap;
    logic [1:0]  cfg_colbits;
    logic        app_req_ack;
    logic        r2b_req;
    logic [1:0]  r2b_ba;
    logic [12:0] r2b_raddr;
    logic [12:0] r2b_caddr;
    logic [7:0]  r2b_len;
    logic        r2b_write;
    logic        b2r_arb_ok;
    logic        page_ovflw;

    int assertions = 0;
    int failures   = 0;

    typedef struct {
        logic [1:0]  ba;
        logic [12:0] row;
        logic [12:0] col;
        logic [7:0]  len;
    } xfer_t;

    xfer_t exp_q[$];

    sdrc_req_splitter dut (
        .sdram_clk    (sdram_clk),
        .sdram_resetn (sdram_resetn),
        .app_req      (app_req),
        .app_req_addr (app_req_addr),
        .app_req_len  (app_req_len),
        .app_req_wr   (app_req_wr),
        .app_req_wrap (app_req_wrap),
        .cfg_colbits  (cfg_colbits),
        .app_req_ack  (app_req_ack),
        .r2b_req      (r2b_req),
        .r2b_ba       (r2b_ba),
        .r2b_raddr    (r2b_raddr),
        .r2b_caddr    (r2b_caddr),
        .r2b_len      (r2b_len),
        .r2b_write    (r2b_write),
        .b2r_arb_ok   (b2r_arb_ok),
        .page_ovflw   (page_ovflw)
    );

    initial sdram_clk = 1'b0;
    always #5 sdram_clk = ~sdram_clk;

    // Reference decode: bank/row/column from a linear address by division.
    function automatic xfer_t make_xfer(input int unsigned addr, input int unsigned colbits,
                                        input int unsigned len);
        int unsigned p;
        xfer_t x;
        p     = 32'd1 << (8 + colbits);
        x.ba  = 2'((addr / p) % 4);
        x.row = 13'((addr / (p * 4)) % 8192);
        x.col = 13'(addr % p);
        x.len = 8'(len);
        return x;
    endfunction

    // Issue one application request and follow it to completion.
    // stall >= 0: b2r_arb_ok low for that many cycles, then high; stall < 0: random.
    task automatic run_req(input string name, input int unsigned addr, input int unsigned len,
                           input bit wr, input bit wrap, input int unsigned colbits,
                           input int stall);
        int unsigned p, col_a, l, l1;
        int  stalls_left;
        int  done;
        int  cycles;
        bit  ack_due;
        bit  post_ack;
        bit  finished;
        bit  exp_req;
        bit  exp_ovf;
        bit  arb;
        xfer_t e;

        // Expected sub-requests from the page rules.
        exp_q.delete();
        p     = 32'd1 << (8 + colbits);
        l     = (len == 0) ? 1 : len;
        col_a = addr % p;
        if (!wrap && (col_a + l > p)) begin
            l1 = p - col_a;
            exp_q.push_back(make_xfer(addr, colbits, l1));
            exp_q.push_back(make_xfer((addr + l1) % (32'd1 << 26), colbits, l - l1));
        end else begin
            exp_q.push_back(make_xfer(addr, colbits, l));
        end

        stalls_left = stall;
        done        = 0;
        cycles      = 0;
        ack_due     = 1'b0;
        post_ack    = 1'b0;
        finished    = 1'b0;

        @(negedge sdram_clk);
        app_req      = 1'b1;
        app_req_addr = 26'(addr);
        app_req_len  = 8'(len);
        app_req_wr   = wr;
        app_req_wrap = wrap;
        cfg_colbits  = 2'(colbits);
        b2r_arb_ok   = 1'b0;

        while (!finished) begin
            @(negedge sdram_clk);
            cycles++;
            // The captured request must not see later colbits changes.
            cfg_colbits = 2'($urandom_range(0, 3));

            exp_req = (exp_q.size() > 0);
            exp_ovf = (done > 0) && (exp_q.size() > 0);

            assertions++;
            if (r2b_req !== exp_req) begin
                failures++;
                $display("FAIL %s r2b_req cycle %0d: got %b expected %b", name, cycles, r2b_req, exp_req);
            end
            assertions++;
            if (app_req_ack !== ack_due) begin
                failures++;
                $display("FAIL %s app_req_ack cycle %0d: got %b expected %b", name, cycles, app_req_ack, ack_due);
            end
            assertions++;
            if (page_ovflw !== exp_ovf) begin
                failures++;
                $display("FAIL %s page_ovflw cycle %0d: got %b expected %b", name, cycles, page_ovflw, exp_ovf);
            end
            if (exp_req) begin
                e = exp_q[0];
                assertions++;
                if (r2b_ba !== e.ba) begin
                    failures++;
                    $display("FAIL %s r2b_ba part %0d: got %0d expected %0d", name, done, r2b_ba, e.ba);
                end
                assertions++;
                if (r2b_raddr !== e.row) begin
                    failures++;
                    $display("FAIL %s r2b_raddr part %0d: got 0x%0h expected 0x%0h", name, done, r2b_raddr, e.row);
                end
                assertions++;
                if (r2b_caddr !== e.col) begin
                    failures++;
                    $display("FAIL %s r2b_caddr part %0d: got 0x%0h expected 0x%0h", name, done, r2b_caddr, e.col);
                end
                assertions++;
                if (r2b_len !== e.len) begin
                    failures++;
                    $display("FAIL %s r2b_len part %0d: got %0d expected %0d", name, done, r2b_len, e.len);
                end
                assertions++;
                if (r2b_write !== wr) begin
                    failures++;
                    $display("FAIL %s r2b_write: got %b expected %b", name, r2b_write, wr);
                end
            end

            if (post_ack) begin
                // app_req was left high through the ack cycle and must have been ignored.
                finished   = 1'b1;
                app_req    = 1'b0;
                b2r_arb_ok = 1'b0;
            end else if (ack_due) begin
                ack_due    = 1'b0;
                post_ack   = 1'b1;
                b2r_arb_ok = 1'($urandom_range(0, 1));
            end else begin
                if (stall >= 0) begin
                    arb = (stalls_left == 0);
                    if (!arb) stalls_left--;
                end else begin
                    arb = 1'($urandom_range(0, 1));
                end
                b2r_arb_ok = arb;
                if (exp_req && arb) begin
                    void'(exp_q.pop_front());
                    done++;
                    if (exp_q.size() == 0) ack_due = 1'b1;
                end
            end

            if (!finished && cycles > 400) begin
                assertions++;
                failures++;
                $display("FAIL %s timeout: got no completion after %0d cycles, expected completion", name, cycles);
                finished   = 1'b1;
                app_req    = 1'b0;
                b2r_arb_ok = 1'b0;
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        assertions++;
        if ({r2b_req, app_req_ack, page_ovflw, r2b_ba, r2b_raddr, r2b_caddr, r2b_len, r2b_write} !== '0) begin
            failures++;
            $display("FAIL %s outputs: got req=%b ack=%b ovf=%b ba=%0d row=0x%0h col=0x%0h len=%0d wr=%b expected all 0",
                     name, r2b_req, app_req_ack, page_ovflw, r2b_ba, r2b_raddr, r2b_caddr, r2b_len, r2b_write);
        end
    endtask

    task automatic test_reset();
        sdram_resetn = 1'b1;
        #1 sdram_resetn = 1'b0;
        repeat (3) begin
            @(negedge sdram_clk);
            check_all_zero("reset");
        end
        sdram_resetn = 1'b1;
        @(negedge sdram_clk);
        check_all_zero("after_reset_idle");
    endtask

    task automatic test_single();
        run_req("single", 32'h0000010, 16, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_page_split();
        run_req("page_split", 32'h00000F0, 32, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_wrap();
        run_req("wrap", 32'h00000F0, 32, 1'b1, 1'b1, 0, 0);
    endtask

    task automatic test_backpressure();
        run_req("backpressure", 32'h0012345, 40, 1'b1, 1'b0, 2, 5);
    endtask

    task automatic test_addr_wrap();
        run_req("addr_wrap", 32'h3FFFFFF, 2, 1'b0, 1'b0, 3, 0);
    endtask

    task automatic test_len_zero();
        run_req("len_zero", 32'h00000FF, 0, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        int unsigned addr;
        for (int i = 0; i < 40; i++) begin
            addr = $urandom_range(0, 32'h03FFFFFF);
            if ($urandom_range(0, 1) == 1) addr = addr | 32'h000007F0;
            run_req($sformatf("random_%0d", i), addr, $urandom_range(0, 255),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 3), -1);
        end
    endtask

    task automatic test_reset_mid_split();
        @(negedge sdram_clk);
        app_req      = 1'b1;
        app_req_addr = 26'h00000F0;
        app_req_len  = 8'd32;
        app_req_wr   = 1'b1;
        app_req_wrap = 1'b0;
        cfg_colbits  = 2'd0;
        b2r_arb_ok   = 1'b0;
        @(negedge sdram_clk);
        assertions++;
        if (r2b_req !== 1'b1 || r2b_caddr !== 13'h0F0 || r2b_len !== 8'd16) begin
            failures++;
            $display("FAIL mid_split first part: got req=%b col=0x%0h len=%0d expected req=1 col=0xf0 len=16",
                     r2b_req, r2b_caddr, r2b_len);
        end
        b2r_arb_ok = 1'b1;
        @(negedge sdram_clk);
        assertions++;
        if (page_ovflw !== 1'b1 || r2b_ba !== 2'd1 || r2b_caddr !== 13'h000) begin
            failures++;
            $display("FAIL mid_split second part: got ovf=%b ba=%0d col=0x%0h expected ovf=1 ba=1 col=0x0",
                     page_ovflw, r2b_ba, r2b_caddr);
        end
        b2r_arb_ok   = 1'b0;
        app_req      = 1'b0;
        sdram_resetn = 1'b0;
        #1 check_all_zero("mid_split_reset");
        repeat (2) @(negedge sdram_clk);
        sdram_resetn = 1'b1;
        b2r_arb_ok   = 1'b1;
        repeat (4) begin
            @(negedge sdram_clk);
            check_all_zero("mid_split_after");
        end
    endtask

    initial begin
        app_req      = 1'b0;
        app_req_addr = '0;
        app_req_len  = '0;
        app_req_wr   = 1'b0;
        app_req_wrap = 1'b0;
        cfg_colbits  = '0;
        b2r_arb_ok   = 1'b0;
        sdram_resetn = 1'b1;

        test_reset();
        test_single();
        test_page_split();
        test_wrap();
        test_backpressure();
        test_addr_wrap();
        test_len_zero();
        test_random();
        test_reset_mid_split();
        test_single();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/sdrc_req_splitter.md
SDRC_REQ_SPLITTER -- requirements
Module: sdrc_req_splitter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all other signals are synchronous to sdram_clk.
REQ-002 sdram_clk  in  1  controller clock; all state changes on the rising edge.
REQ-003 sdram_resetn  in  1  asynchronous, active-low reset.
REQ-004 app_req  in  1  application request valid; held stable until app_req_ack.
REQ-005 app_req_addr  in  26  linear word address.
REQ-006 app_req_len  in  8  burst length in words, 1..255; 0 is treated as 1.
REQ-007 app_req_wr  in  1  1 = write, 0 = read.
REQ-008 app_req_wrap  in  1  1 = burst wraps inside its page and is never split.
REQ-009 cfg_colbits  in  2  column width: 00 = 8, 01 = 9, 10 = 10, 11 = 11 bits.
REQ-010 app_req_ack  out  1  one-cycle pulse: the whole application request has been consumed.
REQ-011 r2b_req  out  1  request valid to the bank controller.
REQ-012 r2b_ba  out  2  bank address.
REQ-013 r2b_raddr  out  13  row address.
REQ-014 r2b_caddr  out  13  column address, zero-extended.
REQ-015 r2b_len  out  8  sub-request length in words.
REQ-016 r2b_write  out  1  copy of the captured app_req_wr.
REQ-017 b2r_arb_ok  in  1  bank FIFO can accept; a transfer occurs on a cycle with r2b_req = 1 and b2r_arb_ok = 1.
REQ-018 page_ovflw  out  1  high while the second half of a split request is pending.

Function
REQ-019 Address map, with C = colbits (8..11):
- caddr = addr[C-1:0]
- ba = addr[C+1:C]
- raddr = addr[C+14:C+2]
REQ-020 The block SHALL use an FSM with states IDLE, ISSUE1 and ISSUE2.
REQ-021 In IDLE, with app_req = 1 and app_req_ack = 0, the block SHALL capture the address, length, write flag, wrap flag and colbits, then move to ISSUE1; r2b_req rises in the next cycle.
REQ-022 Page size P = 2^C. A request SHALL split when wrap = 0 and caddr + len > P.
REQ-023 For a split request the block SHALL compute:
- len1 = P - caddr
- len2 = len - len1
- addr2 = (addr + len1) mod 2^26
REQ-024 In ISSUE1 the block SHALL present the first part (full len if not split) and hold all r2b_* outputs stable until the transfer cycle.
REQ-025 On an ISSUE1 transfer of a split request:
- the next state SHALL be ISSUE2
- r2b_* SHALL present addr2 and len2 in the following cycle
- page_ovflw SHALL be 1 from that cycle until the ISSUE2 transfer.
REQ-026 On an ISSUE1 transfer of an unsplit request, or on any ISSUE2 transfer:
- the next state SHALL be IDLE
- r2b_req SHALL drop
- app_req_ack SHALL be 1 for exactly the next cycle.
REQ-027 In the cycle app_req_ack = 1, IDLE SHALL ignore app_req, so the application can deassert it.
REQ-028 Back-to-back requests SHALL produce at least one r2b_req-low cycle between them.
REQ-029 With wrap = 1 the block SHALL issue one sub-request of the full len; the caddr wrap is the bank controller's job.
REQ-030 Changes on cfg_colbits while a request is in progress SHALL NOT affect that request.
REQ-031 Minimum latency SHALL be: app_req sampled at edge N -> r2b_req at N+1 -> transfer at N+1 if b2r_arb_ok -> app_req_ack at N+2.

Reset
REQ-032 While sdram_resetn = 0 the block SHALL hold:
- state = IDLE
- r2b_req, app_req_ack and page_ovflw = 0
- r2b_ba, r2b_raddr, r2b_caddr, r2b_len and r2b_write = 0.
REQ-033 Reset asserted mid-operation SHALL abort the request: no app_req_ack and no pending second half is issued.
REQ-034 After reset release, the first edge SHALL evaluate IDLE normally.

Verification
REQ-035 Single request: colbits = 00, addr = 0x0000010, len = 16, wrap = 0, arb_ok = 1 -> one transfer with ba = 0, raddr = 0, caddr = 0x10, len = 16; app_req_ack one cycle later.
REQ-036 Page split: colbits = 00, addr = 0x00000F0, len = 32, wrap = 0 -> two transfers:
- first: ba = 0, caddr = 0xF0, len = 16
- second: ba = 1, caddr = 0x000, len = 16
- page_ovflw = 1 between the two transfers; a single app_req_ack.
REQ-037 Wrap: same as REQ-036 with wrap = 1 -> one transfer with caddr = 0xF0, len = 32; page_ovflw never asserted.
REQ-038 Backpressure: b2r_arb_ok held at 0 for 5 cycles -> r2b_* stable for all 5 cycles; no app_req_ack until the transfer.
REQ-039 Address wrap: colbits = 11, addr = 0x3FFFFFF, len = 2, wrap = 0 -> two transfers:
- first: ba = 3, raddr = 0x1FFF, caddr = 0x7FF, len = 1
- second: ba = 0, raddr = 0, caddr = 0, len = 1.
REQ-040 Reset mid-split: sdram_resetn driven to 0 after the first transfer of REQ-036 -> all outputs 0, second half never issued, no app_req_ack.
